// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin slot arbiter.
// Ring-pointer discipline: reset to MSB, rotate right, wrap LSB to MSB.
package rr_arb_pkg;

  localparam int unsigned MaxN = 16;

  // Full-width MSB one-hot; narrowed to the active width by the user.
  localparam logic [MaxN-1:0] PtrRstFull = 16'h8000;

  typedef enum logic {
    StIdle,
    StGrant
  } state_e;

  // Rotate a one-hot vector right by one within an n-bit ring.
  function automatic logic [MaxN-1:0] rotr_onehot(input logic [MaxN-1:0] v,
                                                  input int unsigned    n);
    logic [MaxN-1:0] r;
    r = v >> 1;
    if (v[0]) r[n-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_slot_arbiter_if.sv
// Request/grant bundle between requesting units (master) and the arbiter (slave).
interface rr_slot_arbiter_if #(
  parameter int unsigned N = 6
) ();

  localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IdW-1:0] gnt_id;
  logic           revoked;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  revoked
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output revoked
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set req at or below ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_ptr,
  output logic [N-1:0] o_pick,
  output logic         o_any_req
);

  int  w_start;
  int  w_idx;
  logic w_found;

  always_comb begin
    w_start = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (i_ptr[i]) w_start = i;
    end

    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < int'(N); k++) begin
      w_idx = (w_start - k + int'(N)) % int'(N);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/rr_slot_arbiter.sv
// Round-robin arbiter with registered one-hot grant and zero-bubble handoff.
// Optional hold limit with revoke pulse is enabled by defining RR_ARB_HOLD_LIMIT_EN.
import rr_arb_pkg::*;

module rr_slot_arbiter #(
  parameter int unsigned N        = 6,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rstn,
  rr_slot_arbiter_if.slave  io_bus
);

  localparam int unsigned     IdW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]    PtrRst = N'(PtrRstFull >> (MaxN - N));

  state_e         r_state, w_state_d;
  logic [N-1:0]   r_gnt, w_gnt_d;
  logic [N-1:0]   r_ptr, w_ptr_d;
  logic [N-1:0]   w_rot, w_pick;
  logic           r_revoked, w_revoked_d;
  logic           w_any, w_owner_req, w_vol, w_force, w_release, w_new_grant;
  logic [IdW-1:0] w_gnt_id;

  assign w_owner_req = |(r_gnt & io_bus.req);
  assign w_vol       = (r_state == StGrant) && !w_owner_req;
  assign w_release   = w_vol || w_force;
  assign w_rot       = N'(rotr_onehot(MaxN'(r_gnt), N));
  // The picker sees the post-release pointer so the old owner ranks last.
  assign w_ptr_d     = w_release ? w_rot : r_ptr;
  assign w_new_grant = w_any && ((r_state == StIdle) || w_release);

  rr_pick #(
    .N (N)
  ) u_pick (
    .i_req     (io_bus.req),
    .i_ptr     (w_ptr_d),
    .o_pick    (w_pick),
    .o_any_req (w_any)
  );

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] r_hold_cnt, w_hold_cnt_d;

  // A simultaneous owner drop wins over the limit, so revoked stays low.
  assign w_force = (r_state == StGrant) && w_owner_req && (r_hold_cnt == HoldW'(MAX_HOLD));

  always_comb begin
    w_hold_cnt_d = r_hold_cnt;
    if (w_new_grant) begin
      w_hold_cnt_d = HoldW'(1);
    end else if (w_state_d == StIdle) begin
      w_hold_cnt_d = '0;
    end else if (r_hold_cnt != HoldW'(MAX_HOLD)) begin
      w_hold_cnt_d = r_hold_cnt + HoldW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_d;
    end
  end
`else
  assign w_force = 1'b0 && (MAX_HOLD != 0);
`endif

  always_comb begin
    w_state_d   = r_state;
    w_gnt_d     = r_gnt;
    w_revoked_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_gnt_d   = w_pick;
          w_state_d = StGrant;
        end else begin
          w_gnt_d = '0;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_revoked_d = w_force;
          if (w_any) begin
            w_gnt_d = w_pick;
          end else begin
            w_gnt_d   = '0;
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_gnt_d   = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_gnt     <= '0;
      r_ptr     <= PtrRst;
      r_revoked <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_gnt     <= w_gnt_d;
      r_ptr     <= w_ptr_d;
      r_revoked <= w_revoked_d;
    end
  end

  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (r_gnt[i]) w_gnt_id = IdW'(i);
    end
  end

  assign io_bus.gnt       = r_gnt;
  assign io_bus.gnt_valid = |r_gnt;
  assign io_bus.gnt_id    = w_gnt_id;
  assign io_bus.revoked   = r_revoked;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Directed self-checking bench for rr_slot_arbiter (N=6, MAX_HOLD=4).
// Hold-limit scenarios are built when RR_ARB_HOLD_LIMIT_EN is defined.
module tb_rr_slot_arbiter;

  localparam int unsigned N        = 6;
  localparam int unsigned MAX_HOLD = 4;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  rr_slot_arbiter_if #(.N(N)) arb_if ();

  rr_slot_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] req_during);
    arb_if.req = req_during;
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(6'b111111);
    rstn = 1'b0;
    #1;
    n_checks++;
    if (arb_if.gnt !== 6'b000000) begin
      n_errors++;
      $display("FAIL reset_gnt: got %b expected %b", arb_if.gnt, 6'b000000);
    end
    n_checks++;
    if (arb_if.gnt_id !== 3'd0 || arb_if.gnt_valid !== 1'b0 || arb_if.revoked !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outs: got id=%0d valid=%b rev=%b expected id=0 valid=0 rev=0",
               arb_if.gnt_id, arb_if.gnt_valid, arb_if.revoked);
    end
    rstn = 1'b1;
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b100000 || arb_if.gnt_id !== 3'd5) begin
      n_errors++;
      $display("FAIL reset_first_grant: got %b id=%0d expected 100000 id=5",
               arb_if.gnt, arb_if.gnt_id);
    end
  endtask

  task automatic test_single();
    do_reset(6'b000000);
    arb_if.req = 6'b000100;
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b000100 || arb_if.gnt_id !== 3'd2 || arb_if.gnt_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL single_grant: got %b id=%0d valid=%b expected 000100 id=2 valid=1",
               arb_if.gnt, arb_if.gnt_id, arb_if.gnt_valid);
    end
    tick();
    tick();
    arb_if.req = 6'b000000;
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b000000 || arb_if.gnt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_release: got %b valid=%b expected 000000 valid=0",
               arb_if.gnt, arb_if.gnt_valid);
    end
    tick();
    // Pointer should now sit at bit 1, so bit 1 beats bit 2.
    arb_if.req = 6'b000110;
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b000010) begin
      n_errors++;
      $display("FAIL single_ptr_next: got %b expected %b", arb_if.gnt, 6'b000010);
    end
    arb_if.req = 6'b000000;
    tick();
  endtask

  task automatic test_alternation();
    logic [N-1:0] exp_seq [3];
    exp_seq[0] = 6'b100000;
    exp_seq[1] = 6'b000001;
    exp_seq[2] = 6'b100000;
    do_reset(6'b000000);
    arb_if.req = 6'b100001;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (arb_if.gnt !== exp_seq[s] || arb_if.revoked !== 1'b0) begin
        n_errors++;
        $display("FAIL alt_owner%0d_c1: got %b rev=%b expected %b rev=0",
                 s, arb_if.gnt, arb_if.revoked, exp_seq[s]);
      end
      if (s == 2) break;
      arb_if.req = 6'b100001;
      tick();
      n_checks++;
      if (arb_if.gnt !== exp_seq[s] || arb_if.revoked !== 1'b0) begin
        n_errors++;
        $display("FAIL alt_owner%0d_c2: got %b rev=%b expected %b rev=0",
                 s, arb_if.gnt, arb_if.revoked, exp_seq[s]);
      end
      arb_if.req = 6'b100001 & ~exp_seq[s];
    end
    arb_if.req = 6'b000000;
    tick();
  endtask

`ifdef RR_ARB_HOLD_LIMIT_EN
  task automatic test_contention();
    int owners [7];
    logic [N-1:0] exp_gnt;
    owners = '{5, 4, 3, 2, 1, 0, 5};
    do_reset(6'b000000);
    arb_if.req = 6'b111111;
    for (int k = 0; k < 7; k++) begin
      exp_gnt = 6'b000001 << owners[k];
      for (int c = 0; c < int'(MAX_HOLD); c++) begin
        tick();
        n_checks++;
        if (arb_if.gnt !== exp_gnt) begin
          n_errors++;
          $display("FAIL cont_gnt k%0d c%0d: got %b expected %b", k, c, arb_if.gnt, exp_gnt);
        end
        n_checks++;
        if (arb_if.revoked !== ((c == 0) && (k > 0))) begin
          n_errors++;
          $display("FAIL cont_rev k%0d c%0d: got %b expected %b",
                   k, c, arb_if.revoked, (c == 0) && (k > 0));
        end
      end
    end
  endtask

  task automatic test_limit_edges();
    // Owner drops on the same edge the limit hits: voluntary, no revoke.
    do_reset(6'b000000);
    arb_if.req = 6'b000100;
    repeat (MAX_HOLD) tick();
    arb_if.req = 6'b001000;
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b001000 || arb_if.revoked !== 1'b0) begin
      n_errors++;
      $display("FAIL limit_simul: got %b rev=%b expected 001000 rev=0",
               arb_if.gnt, arb_if.revoked);
    end
    // Lone requester forced out is re-granted immediately.
    do_reset(6'b000000);
    arb_if.req = 6'b000001;
    repeat (MAX_HOLD) tick();
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b000001 || arb_if.revoked !== 1'b1) begin
      n_errors++;
      $display("FAIL limit_regrant: got %b rev=%b expected 000001 rev=1",
               arb_if.gnt, arb_if.revoked);
    end
    arb_if.req = 6'b000000;
    tick();
  endtask
`else
  task automatic test_no_limit();
    do_reset(6'b000000);
    arb_if.req = 6'b001000;
    tick();
    arb_if.req = 6'b111111;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (arb_if.gnt !== 6'b001000 || arb_if.revoked !== 1'b0) begin
        n_errors++;
        $display("FAIL nolimit_hold c%0d: got %b rev=%b expected 001000 rev=0",
                 c, arb_if.gnt, arb_if.revoked);
      end
      // Non-owners toggling must not disturb the grant.
      arb_if.req = (c % 2 == 0) ? 6'b001010 : 6'b111111;
    end
    arb_if.req = 6'b110111;
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b000100 || arb_if.gnt_id !== 3'd2) begin
      n_errors++;
      $display("FAIL nolimit_handoff: got %b id=%0d expected 000100 id=2",
               arb_if.gnt, arb_if.gnt_id);
    end
    arb_if.req = 6'b000000;
    tick();
  endtask
`endif

  task automatic test_mid_reset();
    do_reset(6'b000000);
    arb_if.req = 6'b000100;
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b000100) begin
      n_errors++;
      $display("FAIL midrst_pre: got %b expected %b", arb_if.gnt, 6'b000100);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (arb_if.gnt !== 6'b000000 || arb_if.gnt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_async: got %b valid=%b expected 000000 valid=0",
               arb_if.gnt, arb_if.gnt_valid);
    end
    arb_if.req = 6'b111111;
    tick();
    rstn = 1'b1;
    tick();
    n_checks++;
    if (arb_if.gnt !== 6'b100000) begin
      n_errors++;
      $display("FAIL midrst_first: got %b expected %b", arb_if.gnt, 6'b100000);
    end
    arb_if.req = 6'b000000;
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rstn       = 1'b0;
    arb_if.req = '0;
    test_reset();
    test_single();
    test_alternation();
`ifdef RR_ARB_HOLD_LIMIT_EN
    test_contention();
    test_limit_edges();
`else
    test_no_limit();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_slot_arbiter.md
# rr_slot_arbiter

Round-robin arbiter that shares one datapath resource among N requesters. It uses a one-hot rotating priority pointer with the same ring-counter discipline as the team's timing-signal generator: reset to the MSB, shift right, wrap LSB to MSB. It sits between the requesting control units and the shared resource, issuing a registered one-hot grant and optionally revoking it after a bounded hold time.

## Interface
- N, default 6: number of requesters (2..16).
- MAX_HOLD, default 4: maximum consecutive grant cycles per owner (≥1). Used only when RR_ARB_HOLD_LIMIT_EN is defined.
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- req  input  N  request per requester. Level-sensitive; the owner holds it high while using the resource.
- gnt  output  N  registered one-hot grant, all-zero when idle.
- gnt_valid  output  1  equals |gnt.
- gnt_id  output  $clog2(N)  index of the set gnt bit; 0 when idle.
- revoked  output  1  one-cycle pulse on a forced release by the hold limit. Constant 0 when the macro is absent.

## Operation
- State: IDLE, GRANT. The owner is the index of the set gnt bit.
- ptr: N-bit one-hot search-start pointer. Reset value has bit N-1 set (6'b100000 for N=6).
- Pick: the first set req bit scanning from ptr's bit toward bit 0, wrapping to bit N-1. Pure combinational.
- IDLE:
  - If any req is set at the edge: gnt ← onehot(pick), hold_cnt ← 1, go to GRANT.
  - Otherwise stay in IDLE with gnt = 0.
- GRANT, release condition:
  - Owner's req is low at the edge (voluntary release), or
  - With the macro, hold_cnt == MAX_HOLD (forced release).
- GRANT, on release:
  - ptr ← owner rotated right by one (bit owner-1; bit N-1 if owner = 0).
  - The pick uses the updated ptr, so the owner has lowest priority.
  - If any req is set (the owner's own req counts on forced release), grant directly with no bubble; otherwise gnt ← 0 and go to IDLE.
  - If only the forced-out owner is still requesting, it is re-granted and hold_cnt restarts at 1.
- GRANT, no release: gnt unchanged, hold_cnt increments, saturating at MAX_HOLD.
- Simultaneous voluntary drop and hold limit: treated as voluntary; revoked stays 0.
- Requests raised during a grant wait; they are never preempted except by the hold limit.
- A non-owner may drop req at any time with no effect.
- ptr changes only on release, never while IDLE.

## Timing
- Reset values (asynchronous): gnt = 0, gnt_valid = 0, gnt_id = 0, revoked = 0, state IDLE, hold_cnt = 0, ptr = MSB one-hot.
- Latency:
  - req to gnt: 1 edge.
  - Owner's req drop to gnt change: 1 edge.
  - Handoff to the next requester is in the same edge, with zero idle cycles.
- With the macro, a continuously requesting owner sees gnt for exactly MAX_HOLD cycles.
- revoked is high in the cycle immediately after the forced-release edge.
- gnt_valid and gnt_id derive from registered gnt and are glitch-free.

## Configuration
- RR_ARB_HOLD_LIMIT_EN:
  - Defined: hold_cnt, the forced release and the revoked pulse are present.
  - Undefined: a grant persists until the owner drops req, hold_cnt logic is removed, and revoked is tied to 0.

## Structure
- Package rr_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the function computing the rotate-right of a one-hot vector;
  - the localparam for the ptr reset value.
- One sub-module, rr_pick: combinational rotating priority picker. Inputs req and ptr; outputs the one-hot pick and any_req.

## Test plan
All scenarios use N=6, MAX_HOLD=4.
- Reset: hold rstn low 3 cycles with req = 111111 → gnt = 000000, gnt_id = 0. One edge after release → gnt = 100000, gnt_id = 5.
- Single requester:
  - Raise req[2] → next edge gnt = 000100.
  - Drop req[2] after 3 cycles → next edge gnt = 0, gnt_valid = 0.
  - ptr now points at bit 1.
- Full contention, macro on: req = 111111 held → owners 5,4,3,2,1,0,5, each exactly 4 cycles, no bubble, revoked pulses once per handoff.
- Voluntary alternation:
  - req = 100001; each owner drops req after 2 grant cycles and re-raises it the cycle after.
  - gnt sequence 100000, 000001, 100000; revoked stays 0.
- Macro off: req[3] held 20 cycles while req = 111111 → gnt stays 001000 for all 20 cycles, then hands to bit 2.
- Mid-grant reset: assert rstn while gnt = 000100 → gnt = 0 immediately (before the next edge). After release with req = 111111, the first grant is 100000.
